// File: rtl/mert_acc.sv
// Modular accumulator: sums a job of len reduced products modulo Q.
// Latency: one cycle per accepted beat; result valid the cycle after the last beat.
// Backpressure: in_ready is registered (high only while accumulating); result held until out_ready.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start, len          job request and beat count (len sampled with an accepted start)
//   busy                high from the cycle after an accepted start until the result is taken
//   in_valid/in_ready   beat handshake; in_data is any 32-bit value, pre-reduced below Q here
//   out_valid/out_ready result handshake; out_data = (sum of beats) mod Q
module mert_acc #(
  parameter logic [31:0] Q     = 32'd2181040129,
  parameter int          LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [31:0]      acc_q;
  logic             busy_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // Next accumulator value for the beat on in_data.
  // Q > 2^31, so any 32-bit input needs at most one subtraction to land below Q.
  logic [31:0] x_red;
  logic [32:0] sum_33;
  logic [31:0] acc_d;

  always_comb begin
    x_red  = (in_data >= Q) ? (in_data - Q) : in_data;
    sum_33 = {1'b0, acc_q} + {1'b0, x_red};
    // sum - Q is below 2^32 whenever sum >= Q, so 32-bit wraparound arithmetic is exact.
    acc_d  = (sum_33 >= {1'b0, Q}) ? (sum_33[31:0] - Q) : sum_33[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q  <= len;
            acc_q  <= '0;
            busy_q <= 1'b1;
            if (len == '0) begin
              // Empty job: result (0) is presented immediately.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= ACC;
              in_ready_q <= 1'b1;
            end
          end
        end

        ACC: begin
          if (in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            // Stopping at a count of one means the counter never wraps, even for len = all ones.
            if (cnt_q == LEN_W'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  // The accumulator is frozen outside ACC, so it doubles as the result register.
  assign out_data  = acc_q;

endmodule

// File: tb/tb_mert_acc.sv
// Self-checking bench for mert_acc: directed jobs, randomized jobs and a max-length job.
// Expected results come from a plain 64-bit sum of the beats taken modulo Q.
// Inputs are driven just after the falling edge; outputs are sampled at the falling edge.
module tb_mert_acc;

  localparam logic [31:0] Q     = 32'd2181040129;
  localparam int          LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] beats[$];

  always #5 clk = ~clk;

  mert_acc #(.Q(Q), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: the job result is the arithmetic sum of the beats, modulo Q.
  function automatic logic [31:0] ref_result();
    longint unsigned s = 0;
    foreach (beats[i]) s += 64'(beats[i]);
    return 32'(s % 64'(Q));
  endfunction

  function automatic logic [31:0] pick_beat();
    case ($urandom_range(0, 4))
      0:       return Q - 32'd1;
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      2:       return Q + 32'($urandom_range(0, 3));
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  // Runs one job with the beats in 'beats'. Called just after a falling edge.
  // gaps: randomly drop in_valid; hold: cycles out_ready stays low; poke: pulse start where it must be ignored.
  task automatic do_job(input int n, input bit gaps, input int hold, input bit poke);
    logic [31:0] exp;
    int idx;
    int cyc;
    exp = ref_result();
    idx = 0;
    cyc = 0;
    start = 1'b1;
    len   = LEN_W'(n);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (n == 0) begin
      check("len0_out_valid", out_valid, 1);
      check("len0_in_ready", in_ready, 0);
    end else begin
      while (idx < n && cyc < 4 * n + 16) begin
        check("in_ready_acc", in_ready, 1);
        check("out_valid_acc", out_valid, 0);
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = beats[idx];
        start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        len      = LEN_W'($urandom);
        @(negedge clk);
        if (in_valid) idx++;
        cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check("beats_accepted", 64'(idx), 64'(n));
      check("out_valid_after_last", out_valid, 1);
      check("in_ready_done", in_ready, 0);
    end
    check("out_data", out_data, exp);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_data", out_data, exp);
      check("hold_busy", busy, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    start     = poke;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_busy", busy, 0);
    check("post_hs_in_ready", in_ready, 0);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    // Sum lands exactly on Q -> 0
    beats = '{Q - 32'd1, Q - 32'd1, 32'd2};
    do_job(3, 1'b0, 0, 1'b0);

    // Inputs above Q are pre-reduced
    beats = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    do_job(2, 1'b0, 0, 1'b0);
    check("const_0xffffffff_pair", out_data, 32'd2046814203);

    // Empty job
    beats = {};
    do_job(0, 1'b0, 1, 1'b0);

    // Gapped input, held output, starts poked in ACC and DONE
    beats = '{Q - 32'd1, Q - 32'd1};
    do_job(2, 1'b1, 5, 1'b1);

    // Asynchronous reset mid-job
    start = 1'b1;
    len   = LEN_W'(4);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'd1;
    @(negedge clk);
    in_data = 32'd2;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    beats = '{32'd7};
    do_job(1, 1'b0, 0, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(1, 9);
      beats = {};
      for (int k = 0; k < n; k++) beats.push_back(pick_beat());
      do_job(n, 1'b1, $urandom_range(0, 3), 1'b1);
    end

    // Maximum job length
    beats = {};
    for (int k = 0; k < (1 << LEN_W) - 1; k++) beats.push_back(pick_beat());
    do_job((1 << LEN_W) - 1, 1'b0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
